// File: rtl/vedic_pkg.sv
// Shared widths and the 3-bit carry-lookahead (CBL) primitive for the Vedic multiplier
// accumulation stage.
package vedic_pkg;

  localparam int unsigned HALF_DEF = 4;
  localparam int unsigned PP_W     = 2 * HALF_DEF;
  localparam int unsigned PROD_W   = 4 * HALF_DEF;

  // Returns {carry_out, sum[2:0]}. Zero-padded upper bits make bit k equal the carry into
  // bit k, so a truncated block reads its carry-out from bit W of the result.
  function automatic logic [3:0] cbl3(input logic [2:0] a, input logic [2:0] b,
                                      input logic cin);
    logic [2:0] g;
    logic [2:0] p;
    logic [3:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return {c[3], p ^ c[2:0]};
  endfunction

endpackage

// File: rtl/vedic_pp_accumulate_if.sv
// Valid/ready bus carrying the four partial products in and the product out.
interface vedic_pp_accumulate_if
  import vedic_pkg::*;
#(
  parameter int unsigned HALF = HALF_DEF
) ();

  logic                in_valid;
  logic                in_ready;
  logic [2*HALF-1:0]   pp_ll;
  logic [2*HALF-1:0]   pp_hl;
  logic [2*HALF-1:0]   pp_lh;
  logic [2*HALF-1:0]   pp_hh;
  logic                out_valid;
  logic                out_ready;
  logic [4*HALF-1:0]   product;

  modport master (
    output in_valid, pp_ll, pp_hl, pp_lh, pp_hh, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, pp_ll, pp_hl, pp_lh, pp_hh, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/csla_adder.sv
// Combinational carry-select adder built from 3-bit CBL blocks; the last block is
// truncated to WIDTH mod 3 bits.
module csla_adder
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NumBlk = (WIDTH + 2) / 3;

  logic [NumBlk:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < NumBlk; gi++) begin : g_blk
    localparam int unsigned Lo = 3 * gi;
    localparam int unsigned W  = ((WIDTH - Lo) >= 3) ? 3 : (WIDTH - Lo);

    logic [W:0] r0;
    logic [W:0] r1;

    // Both carry-in hypotheses are computed up front; the incoming carry only selects.
    assign r0 = (W + 1)'(cbl3(3'(a[Lo +: W]), 3'(b[Lo +: W]), 1'b0));
    assign r1 = (W + 1)'(cbl3(3'(a[Lo +: W]), 3'(b[Lo +: W]), 1'b1));

    assign sum[Lo +: W]  = carry[gi] ? r1[W-1:0] : r0[W-1:0];
    assign carry[gi + 1] = carry[gi] ? r1[W]     : r0[W];
  end

  assign cout = carry[NumBlk];

endmodule

// File: rtl/vedic_pp_accumulate.sv
// Three-stage valid/ready pipeline computing P = (HH<<8) + ((HL+LH)<<4) + LL from the
// four 4x4 Vedic partial products.
module vedic_pp_accumulate
  import vedic_pkg::*;
#(
  parameter int unsigned HALF = HALF_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  vedic_pp_accumulate_if.slave  bus
);

  localparam int unsigned PpW = 2 * HALF;

  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;

  logic [PpW:0]   mid_q;
  logic [PpW-1:0] ll1_q, hh1_q;
  logic [PpW-1:0] lo2_q, hh2_q;
  logic           clo2_q;
  logic [HALF:0]  midhi2_q;
  logic [2*PpW-1:0] product_q;

  logic [PpW-1:0] mid_sum, lo_sum, hi_sum, lo_b, hi_b;
  logic           mid_cout, lo_cout, hi_cout_unused;

  always_comb begin
    adv3 = !v3_q || bus.out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3_q;
  assign bus.product   = product_q;

  assign lo_b = {mid_q[HALF-1:0], {HALF{1'b0}}};
  assign hi_b = PpW'(midhi2_q);

  csla_adder #(.WIDTH(PpW)) u_s1_mid (
    .a    (bus.pp_hl),
    .b    (bus.pp_lh),
    .cin  (1'b0),
    .sum  (mid_sum),
    .cout (mid_cout)
  );

  csla_adder #(.WIDTH(PpW)) u_s2_lo (
    .a    (ll1_q),
    .b    (lo_b),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // Legal partial products never carry out of the high half.
  csla_adder #(.WIDTH(PpW)) u_s3_hi (
    .a    (hh2_q),
    .b    (hi_b),
    .cin  (clo2_q),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  // Data registers load only with valid upstream data, so nothing stale reaches product.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      mid_q     <= '0;
      ll1_q     <= '0;
      hh1_q     <= '0;
      lo2_q     <= '0;
      clo2_q    <= 1'b0;
      hh2_q     <= '0;
      midhi2_q  <= '0;
      product_q <= '0;
    end else begin
      if (adv1) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          mid_q <= {mid_cout, mid_sum};
          ll1_q <= bus.pp_ll;
          hh1_q <= bus.pp_hh;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          lo2_q    <= lo_sum;
          clo2_q   <= lo_cout;
          hh2_q    <= hh1_q;
          midhi2_q <= mid_q[PpW:HALF];
        end
      end
      if (adv3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          product_q <= {hi_sum, lo2_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_vedic_pp_accumulate.sv
// Directed bench: expected products (A*B) are queued on accept and compared on output.
module tb_vedic_pp_accumulate;
  import vedic_pkg::*;

  typedef struct {
    logic [PROD_W-1:0] prod;
    int                cyc;
    bit                lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vedic_pp_accumulate_if #(.HALF(HALF_DEF)) bus ();

  vedic_pp_accumulate #(.HALF(HALF_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t              q[$];
  logic [PROD_W-1:0] cur_exp;
  logic [PROD_W-1:0] p_hold;
  bit                lat_chk;
  int                cyc;
  int                n_acc;
  int                n_out;
  int                n0;
  int                m0;
  int                checks;
  int                errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    bus.pp_ll    = PP_W'(a[3:0]) * PP_W'(b[3:0]);
    bus.pp_hl    = PP_W'(a[7:4]) * PP_W'(b[3:0]);
    bus.pp_lh    = PP_W'(a[3:0]) * PP_W'(b[7:4]);
    bus.pp_hh    = PP_W'(a[7:4]) * PP_W'(b[7:4]);
    cur_exp      = PROD_W'(a) * PROD_W'(b);
    bus.in_valid = 1'b1;
  endtask

  // One clock: observe handshakes at the falling edge, then return just after the rise.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{prod: cur_exp, cyc: cyc, lat: lat_chk});
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_out: observed product %0h expected no output", bus.product);
        end else begin
          e = q.pop_front();
          check("product", 32'(bus.product), 32'(e.prod));
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) tick();
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    n_acc         = 0;
    n_out         = 0;
    lat_chk       = 1'b1;
    cur_exp       = '0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.pp_ll     = '0;
    bus.pp_hl     = '0;
    bus.pp_lh     = '0;
    bus.pp_hh     = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed single products.
    bus.out_ready = 1'b1;
    drive(8'hFF, 8'hFF);
    check("pp_e1", 32'(bus.pp_hh), 32'h0E1);
    tick();
    bus.in_valid = 1'b0;
    drain();
    drive(8'h12, 8'h34);
    tick();
    bus.in_valid = 1'b0;
    drain();
    drive(8'h00, 8'h00);
    tick();
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back streaming.
    n0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      drive(8'($urandom), 8'($urandom));
      tick();
    end
    bus.in_valid = 1'b0;
    check("stream_accepts", 32'(n_acc - n0), 32'd6);
    drain();

    // Backpressure fills the pipeline, then release with a simultaneous accept.
    lat_chk       = 1'b0;
    bus.out_ready = 1'b0;
    n0            = n_acc;
    m0            = n_out;
    for (int i = 0; i < 6; i++) begin
      drive(8'($urandom), 8'($urandom));
      tick();
    end
    check("full_accepts", 32'(n_acc - n0), 32'd3);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    p_hold = bus.product;
    repeat (3) tick();
    check("hold_product", 32'(bus.product), 32'(p_hold));
    drive(8'($urandom), 8'($urandom));
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("release_accepts", 32'(n_acc - n0), 32'd4);
    drain();
    check("release_outputs", 32'(n_out - m0), 32'd4);

    // Reset with two sets in flight.
    lat_chk = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(8'($urandom), 8'($urandom));
      tick();
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    tick();
    q.delete();
    rst = 1'b0;
    #1;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_product", 32'(bus.product), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    m0 = n_out;
    repeat (8) tick();
    check("flush_no_output", 32'(n_out - m0), 32'd0);

    drive(8'hA5, 8'h5A);
    tick();
    bus.in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
